// File: rtl/ad9833_pkg.sv
// Shared definitions for the AD9833 sweep sequencer: FSM encoding,
// control-register bit positions and waveform masks.
package ad9833_pkg;

    localparam int FREQ_W_DEF = 28;

    // AD9833 control register bits
    localparam logic [15:0] CTRL_B28     = 16'h2000;
    localparam logic [15:0] CTRL_OPBITEN = 16'h0020;
    localparam logic [15:0] CTRL_DIV2    = 16'h0008;
    localparam logic [15:0] CTRL_MODE    = 16'h0002;

    // Waveform masks OR-ed onto B28
    localparam logic [15:0] WAVE_SINE       = 16'h0000;
    localparam logic [15:0] WAVE_TRIANGLE   = CTRL_MODE;
    localparam logic [15:0] WAVE_SQUARE     = CTRL_OPBITEN | CTRL_DIV2;
    localparam logic [15:0] WAVE_SQUARE_DIV = CTRL_OPBITEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CPL,
        S_DWELL,
        S_STEP,
        S_DONE
    } state_t;

    // Map the 2-bit waveform selector onto its control-word mask
    function automatic logic [15:0] wave_mask(input logic [1:0] sel);
        logic [15:0] m;
        case (sel)
            2'd1:    m = WAVE_TRIANGLE;
            2'd2:    m = WAVE_SQUARE;
            2'd3:    m = WAVE_SQUARE_DIV;
            default: m = WAVE_SINE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ad9833_dwell_timer.sv
// Dwell counter: cleared on entry to the dwell phase, counts while enabled,
// and flags expiry on the last dwell clock (or immediately for a zero limit).
module ad9833_dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               expired
);

    logic [DWELL_W-1:0] count_reg;

    // Count register: clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + DWELL_W'(1);
        end
    end

    // A zero limit expires at once; otherwise on count == limit-1
    assign expired = (limit == '0) || (count_reg == limit - DWELL_W'(1));

endmodule

// File: rtl/ad9833_sweep_seq.sv
// Linear frequency-sweep sequencer feeding the AD9833 serial interface.
// One go/ack handshake per point, dwell after each completed write, then
// step until the next word would pass stop_freq or overflow the 28-bit word.
module ad9833_sweep_seq
    import ad9833_pkg::*;
#(
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  start_freq,
    input  logic [FREQ_W-1:0]  stop_freq,
    input  logic [FREQ_W-1:0]  step_freq,
    input  logic [DWELL_W-1:0] dwell_clks,
    input  logic [1:0]         wave_sel,
    output logic               go,
    output logic [15:0]        control,
    output logic [31:0]        freq,
    input  logic               good_to_reset_go,
    input  logic               send_complete,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [FREQ_W-1:0]  cur_freq
);

    state_t              state_reg, state_next;
    logic [FREQ_W-1:0]   cur_freq_reg, stop_reg, step_reg;
    logic [DWELL_W-1:0]  dwell_reg;
    logic [15:0]         control_reg;
    logic                aborted_reg, abort_pending_reg;

    logic                load, advance, pend_set, abort_hit;
    logic                timer_clear, timer_en, timer_expired;
    logic [FREQ_W:0]     sum;
    logic                sweep_end;

    // Next point with carry; the carry bit catches wrap past 2^FREQ_W
    assign sum       = {1'b0, cur_freq_reg} + {1'b0, step_reg};
    assign sweep_end = sum[FREQ_W] || (sum[FREQ_W-1:0] > stop_reg) || (step_reg == '0);

    ad9833_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .en      (timer_en),
        .limit   (dwell_reg),
        .expired (timer_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_next  = state_reg;
        load        = 1'b0;
        advance     = 1'b0;
        pend_set    = 1'b0;
        abort_hit   = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Start wins over a coincident abort; abort alone is ignored here
                if (start && !good_to_reset_go) begin
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) pend_set = 1'b1;
                if (good_to_reset_go) state_next = S_WAIT_CPL;
            end
            S_WAIT_CPL: begin
                // The downstream cannot be cancelled, so a pending abort
                // takes effect only once the frame has gone out
                if (abort) pend_set = 1'b1;
                if (send_complete) begin
                    if (abort_pending_reg || abort) begin
                        abort_hit  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        timer_clear = 1'b1;
                        state_next  = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_DONE;
                end else if (timer_expired) begin
                    state_next = S_STEP;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_STEP: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_DONE;
                end else if (sweep_end) begin
                    state_next = S_DONE;
                end else if (!good_to_reset_go) begin
                    advance    = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sweep parameters, current word and abort flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_freq_reg      <= '0;
            stop_reg          <= '0;
            step_reg          <= '0;
            dwell_reg         <= '0;
            control_reg       <= CTRL_B28;
            aborted_reg       <= 1'b0;
            abort_pending_reg <= 1'b0;
        end else if (load) begin
            cur_freq_reg      <= start_freq;
            stop_reg          <= stop_freq;
            step_reg          <= step_freq;
            dwell_reg         <= dwell_clks;
            control_reg       <= CTRL_B28 | wave_mask(wave_sel);
            aborted_reg       <= 1'b0;
            abort_pending_reg <= 1'b0;
        end else begin
            if (advance)   cur_freq_reg      <= sum[FREQ_W-1:0];
            if (pend_set)  abort_pending_reg <= 1'b1;
            if (abort_hit) aborted_reg       <= 1'b1;
        end
    end

    assign go       = (state_reg == S_ISSUE);
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign aborted  = aborted_reg;
    assign control  = control_reg;
    assign cur_freq = cur_freq_reg;
    assign freq     = {{(32 - FREQ_W){1'b0}}, cur_freq_reg};

endmodule

// File: tb/tb_ad9833_sweep_seq.sv
// Bench for ad9833_sweep_seq: a downstream serial-interface model plus a
// scoreboard of expected writes and done events checked by a monitor.
module tb_ad9833_sweep_seq;
    import ad9833_pkg::*;

    localparam int FREQ_W       = 28;
    localparam int DWELL_W      = 32;
    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME_CLKS   = 32 * CLKS_PER_BIT;
    localparam int TAIL         = 3;

    logic               clk, rst, start, abort;
    logic [FREQ_W-1:0]  start_freq, stop_freq, step_freq;
    logic [DWELL_W-1:0] dwell_clks;
    logic [1:0]         wave_sel;
    logic               go, good_to_reset_go, send_complete;
    logic [15:0]        control;
    logic [31:0]        freq;
    logic               busy, done, aborted;
    logic [FREQ_W-1:0]  cur_freq;

    typedef struct {
        logic [FREQ_W-1:0] f;
        logic [15:0]       c;
        int                min_gap;
    } wr_t;

    wr_t exp_wr[$];
    bit  exp_done[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sc_cyc = 0;
    int go_rises = 0;
    int m_state = 0;
    int m_cnt = 0;

    ad9833_sweep_seq #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .start_freq       (start_freq),
        .stop_freq        (stop_freq),
        .step_freq        (step_freq),
        .dwell_clks       (dwell_clks),
        .wave_sel         (wave_sel),
        .go               (go),
        .control          (control),
        .freq             (freq),
        .good_to_reset_go (good_to_reset_go),
        .send_complete    (send_complete),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
        .cur_freq         (cur_freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream model: ack go, shift a frame, pulse complete, release ack later.
    // Deliberately not reset by rst: the frame finishes regardless.
    initial begin
        good_to_reset_go = 1'b0;
        send_complete    = 1'b0;
        forever begin
            @(negedge clk);
            case (m_state)
                0: if (go === 1'b1) begin
                    good_to_reset_go = 1'b1;
                    m_cnt   = FRAME_CLKS;
                    m_state = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        send_complete = 1'b1;
                        last_sc_cyc   = cyc;
                        m_cnt   = TAIL;
                        m_state = 2;
                    end
                end
                default: begin
                    send_complete = 1'b0;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        good_to_reset_go = 1'b0;
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: each go rising edge is one write; each done pulse one sweep end
    initial begin
        wr_t  e;
        logic prev_go;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (go === 1'b1 && prev_go !== 1'b1) begin
                go_rises++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_go: got freq %0h expected no write", freq);
                end else begin
                    e = exp_wr.pop_front();
                    $display("write freq=%0h control=%0h gap=%0d", freq, control, cyc - last_sc_cyc);
                    check("write_freq", freq, {4'b0, e.f});
                    check("write_control", {16'b0, control}, {16'b0, e.c});
                    if (e.min_gap > 0) begin
                        checks++;
                        if (cyc - last_sc_cyc < e.min_gap) begin
                            errors++;
                            $display("FAIL dwell_gap: got %0d expected >= %0d", cyc - last_sc_cyc, e.min_gap);
                        end
                    end
                end
            end
            prev_go = go;
            if (done === 1'b1) begin
                $display("done aborted=%0b", aborted);
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    check("done_aborted", {31'b0, aborted}, {31'b0, exp_done.pop_front()});
                end
            end
        end
    end

    task automatic push_wr(input logic [FREQ_W-1:0] f, input logic [15:0] c, input int gap);
        wr_t e;
        e.f = f;
        e.c = c;
        e.min_gap = gap;
        exp_wr.push_back(e);
    endtask

    task automatic do_start(input logic [FREQ_W-1:0] sf, input logic [FREQ_W-1:0] pf,
                            input logic [FREQ_W-1:0] st, input logic [DWELL_W-1:0] dw,
                            input logic [1:0] ws, input logic with_abort);
        @(negedge clk);
        start_freq = sf;
        stop_freq  = pf;
        step_freq  = st;
        dwell_clks = dw;
        wave_sel   = ws;
        start      = 1'b1;
        abort      = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        // scramble inputs: latched copies must be used
        start_freq = 28'h0ABCDEF;
        stop_freq  = 28'h0000001;
        step_freq  = 28'h0000007;
        wave_sel   = 2'd1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || m_state != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check({name, "_timeout"}, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        check({name, "_writes_left"}, exp_wr.size(), 32'd0);
        check({name, "_done_left"}, exp_done.size(), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_freq = '0; stop_freq = '0; step_freq = '0; dwell_clks = '0; wave_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_go", {31'b0, go}, 32'd0);
        check("rst_control", {16'b0, control}, 32'h2000);
        check("rst_freq", freq, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_aborted", {31'b0, aborted}, 32'd0);
        check("rst_cur_freq", {4'b0, cur_freq}, 32'd0);
        rst = 1'b0;

        // Basic sweep: 1000..1300 step 100, dwell 10, sine
        push_wr(28'd1000, 16'h2000, 0);
        push_wr(28'd1100, 16'h2000, 10);
        push_wr(28'd1200, 16'h2000, 10);
        push_wr(28'd1300, 16'h2000, 10);
        exp_done.push_back(1'b0);
        do_start(28'd1000, 28'd1300, 28'd100, 32'd10, 2'd0, 1'b0);
        wait_idle("basic");

        // Single point (start > stop), square/2; abort in the start cycle is ignored
        push_wr(28'd500, 16'h2020, 0);
        exp_done.push_back(1'b0);
        do_start(28'd500, 28'd400, 28'd10, 32'd3, 2'd3, 1'b1);
        wait_idle("single");

        // Carry out of the 28-bit word ends the sweep
        push_wr(28'hFFFFF00, 16'h2000, 0);
        exp_done.push_back(1'b0);
        do_start(28'hFFFFF00, 28'hFFFFFFF, 28'h100, 32'd4, 2'd0, 1'b0);
        wait_idle("overflow");

        // Zero step and zero dwell, square
        push_wr(28'd700, 16'h2028, 0);
        exp_done.push_back(1'b0);
        do_start(28'd700, 28'd900, 28'd0, 32'd0, 2'd2, 1'b0);
        wait_idle("zero_step");

        // Abort during WAIT_CPL of the second point, triangle
        push_wr(28'd100, 16'h2002, 0);
        push_wr(28'd200, 16'h2002, 5);
        exp_done.push_back(1'b1);
        base = go_rises;
        do_start(28'd100, 28'd500, 28'd100, 32'd5, 2'd1, 1'b0);
        n = 0;
        while (go_rises < base + 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_second_go_seen", (go_rises >= base + 2) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort");
        check("abort_held", {31'b0, aborted}, 32'd1);

        // Reset in the middle of ISSUE, then restart
        push_wr(28'd2000, 16'h2000, 0);
        do_start(28'd2000, 28'd2000, 28'd1, 32'd2, 2'd0, 1'b0);
        check("go_before_reset", {31'b0, go}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_go", {31'b0, go}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_control", {16'b0, control}, 32'h2000);
        check("async_rst_cur_freq", {4'b0, cur_freq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(28'd3000, 28'd3000, 28'd1, 32'd2, 2'd0, 1'b0);
        check("start_ignored_while_ack", {31'b0, busy}, 32'd0);
        n = 0;
        while (good_to_reset_go !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ack_release_timeout", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        push_wr(28'd2000, 16'h2000, 0);
        exp_done.push_back(1'b0);
        do_start(28'd2000, 28'd2000, 28'd1, 32'd2, 2'd0, 1'b0);
        check("restart_busy", {31'b0, busy}, 32'd1);
        wait_idle("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
